carfield_island_err_resp: RTL and testbench

Terminating AXI4 responder for address windows whose island is compiled out (Enable = 0 in `carfield_configuration`: safety island, Ethernet, PULP cluster, security island, CAN). The crossbar routes any access hitting a disabled window to this block. It accepts every request and completes it protocol-correctly with DECERR, so no initiator ever hangs. It also logs the first offending access and counts all of them for software diagnosis.

---
 rtl/carfield_pkg.sv | 23 ++
 rtl/carfield_err_resp_fifo.sv | 55 +++++
 rtl/carfield_island_err_resp.sv | 188 ++++++++++++++++++
 tb/tb_carfield_island_err_resp.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/carfield_pkg.sv
// Shared constants and types for the Carfield disabled-island error responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: DECERR response code, default read-data pattern, and the request
// buffer entry type. Entry fields are sized to the widest supported
// configuration; narrower instances zero-extend into them.
package carfield_pkg;

    localparam logic [1:0]  AXI_RESP_DECERR = 2'b11;
    localparam logic [63:0] ERR_RESP_DATA   = 64'hBADC_AB1E_BADC_AB1E;

    localparam int unsigned ERR_RESP_MAX_ID_W   = 16;
    localparam int unsigned ERR_RESP_MAX_ADDR_W = 64;
    localparam int unsigned ERR_RESP_LEN_W      = 8;

    typedef struct packed {
        logic [ERR_RESP_MAX_ID_W-1:0]   id;
        logic [ERR_RESP_MAX_ADDR_W-1:0] addr;
        logic [ERR_RESP_LEN_W-1:0]      len;
    } err_resp_entry_t;

endpackage

// File: rtl/carfield_err_resp_fifo.sv
// Generic synchronous FIFO holding pending requests of the error responder.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: full_o blocks pushes, except a push paired with a pop while full.
//
// Ports: clk_i/rst_i clock and async active-high reset; push_i/wdata_i write
// side; pop_i read side (head is rdata_o); full_o/empty_o status flags.
module carfield_err_resp_fifo
    import carfield_pkg::*;
#(
    parameter int unsigned Depth   = 4,
    parameter type         entry_t = err_resp_entry_t
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push_i,
    input  entry_t wdata_i,
    input  logic   pop_i,
    output entry_t rdata_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] PtrOne = 1;

    // One extra pointer bit distinguishes full from empty.
    logic [PtrW:0] r_wptr;
    logic [PtrW:0] r_rptr;
    entry_t        r_mem [Depth];
    logic          w_push;
    logic          w_pop;

    assign empty_o = (r_wptr == r_rptr);
    assign full_o  = (r_wptr[PtrW] != r_rptr[PtrW]) &&
                     (r_wptr[PtrW-1:0] == r_rptr[PtrW-1:0]);
    assign w_pop   = pop_i && !empty_o;
    // While full, the slot freed by a same-cycle pop is the one being written.
    assign w_push  = push_i && (!full_o || w_pop);
    assign rdata_o = r_mem[r_rptr[PtrW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PtrOne;
            if (w_pop)  r_rptr <= r_rptr + PtrOne;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr[PtrW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/carfield_island_err_resp.sv
// AXI4 terminator for disabled-island windows: completes every access with DECERR and logs faults.
// Latency: W accepted from the cycle after AW; B the cycle after w_last; first R beat 2 cycles after AR.
// Backpressure: aw/ar ready drop when their request buffer is full; W held off until its AW is buffered.
//
// Ports: clk_i/rst_i clock and async active-high reset; AW/W/B and AR/R AXI4
// channels (subset); err_clear_i clears the log; err_valid_o/err_addr_o/
// err_write_o describe the first fault, err_count_o counts all (saturating).
module carfield_island_err_resp
    import carfield_pkg::*;
#(
    parameter int unsigned IdWidth   = 6,
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned MaxTxns   = 4,
    parameter logic [63:0] RespData  = ERR_RESP_DATA
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic                 w_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [7:0]           ar_len_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,
    input  logic                 err_clear_i,
    output logic                 err_valid_o,
    output logic [AddrWidth-1:0] err_addr_o,
    output logic                 err_write_o,
    output logic [15:0]          err_count_o
);

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_DRAIN = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;
    localparam logic [0:0] R_IDLE  = 1'b0;
    localparam logic [0:0] R_BURST = 1'b1;

    err_resp_entry_t w_aw_entry, w_ar_entry, w_aw_head, w_ar_head;
    logic            w_aw_full, w_aw_empty, w_ar_full, w_ar_empty;
    logic            w_aw_hs, w_ar_hs, w_aw_pop, w_ar_pop;
    logic [1:0]      r_w_state;
    logic [0:0]      r_r_state;
    logic [7:0]      r_beat_cnt;
    logic [16:0]     w_cnt_sum;
    logic            r_err_valid, r_err_write;
    logic [AddrWidth-1:0] r_err_addr;
    logic [15:0]     r_err_count;
    logic            w_unused;

    always_comb begin
        w_aw_entry = '0;
        w_aw_entry.id[IdWidth-1:0]     = aw_id_i;
        w_aw_entry.addr[AddrWidth-1:0] = aw_addr_i;
        w_ar_entry = '0;
        w_ar_entry.id[IdWidth-1:0]     = ar_id_i;
        w_ar_entry.addr[AddrWidth-1:0] = ar_addr_i;
        w_ar_entry.len                 = ar_len_i;
    end

    // Only head IDs and the AR length are consumed downstream.
    assign w_unused = ^{w_aw_head, w_ar_head};

    // Readies are forced low while reset is held.
    assign aw_ready_o = !w_aw_full && !rst_i;
    assign ar_ready_o = !w_ar_full && !rst_i;
    assign w_aw_hs    = aw_valid_i && aw_ready_o;
    assign w_ar_hs    = ar_valid_i && ar_ready_o;
    assign w_aw_pop   = (r_w_state == W_RESP) && b_ready_i;
    assign w_ar_pop   = (r_r_state == R_BURST) && r_ready_i && (r_beat_cnt == 8'd0);

    carfield_err_resp_fifo #(.Depth(MaxTxns), .entry_t(err_resp_entry_t)) u_aw_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (w_aw_hs),
        .wdata_i(w_aw_entry),
        .pop_i  (w_aw_pop),
        .rdata_o(w_aw_head),
        .full_o (w_aw_full),
        .empty_o(w_aw_empty)
    );

    carfield_err_resp_fifo #(.Depth(MaxTxns), .entry_t(err_resp_entry_t)) u_ar_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (w_ar_hs),
        .wdata_i(w_ar_entry),
        .pop_i  (w_ar_pop),
        .rdata_o(w_ar_head),
        .full_o (w_ar_full),
        .empty_o(w_ar_empty)
    );

    // Write side. IDLE also looks at the incoming AW handshake so W beats can
    // be drained on the very next cycle instead of waiting for the FIFO flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_w_state <= W_IDLE;
        end else begin
            case (r_w_state)
                W_IDLE:  if (!w_aw_empty || w_aw_hs) r_w_state <= W_DRAIN;
                W_DRAIN: if (w_valid_i && w_last_i)  r_w_state <= W_RESP;
                W_RESP:  if (b_ready_i)              r_w_state <= W_IDLE;
                default: r_w_state <= W_IDLE;
            endcase
        end
    end

    assign w_ready_o = (r_w_state == W_DRAIN);
    assign b_valid_o = (r_w_state == W_RESP);
    assign b_id_o    = b_valid_o ? w_aw_head.id[IdWidth-1:0] : '0;
    assign b_resp_o  = AXI_RESP_DECERR;

    // Read side: the beat counter holds beats remaining after the current one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_r_state  <= R_IDLE;
            r_beat_cnt <= '0;
        end else begin
            case (r_r_state)
                R_IDLE: begin
                    if (!w_ar_empty) begin
                        r_beat_cnt <= w_ar_head.len;
                        r_r_state  <= R_BURST;
                    end
                end
                R_BURST: begin
                    if (r_ready_i) begin
                        if (r_beat_cnt == 8'd0) r_r_state  <= R_IDLE;
                        else                    r_beat_cnt <= r_beat_cnt - 8'd1;
                    end
                end
                default: r_r_state <= R_IDLE;
            endcase
        end
    end

    assign r_valid_o = (r_r_state == R_BURST);
    assign r_last_o  = r_valid_o && (r_beat_cnt == 8'd0);
    assign r_id_o    = r_valid_o ? w_ar_head.id[IdWidth-1:0] : '0;
    assign r_data_o  = r_valid_o ? DataWidth'(RespData) : '0;
    assign r_resp_o  = AXI_RESP_DECERR;

    // Error log. A simultaneous AW+AR counts twice and the write wins capture.
    assign w_cnt_sum = {1'b0, r_err_count} + {16'd0, w_aw_hs} + {16'd0, w_ar_hs};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err_valid <= 1'b0;
            r_err_write <= 1'b0;
            r_err_addr  <= '0;
            r_err_count <= '0;
        end else if (err_clear_i) begin
            r_err_valid <= 1'b0;
            r_err_write <= 1'b0;
            r_err_addr  <= '0;
            r_err_count <= '0;
        end else begin
            r_err_count <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
            if (!r_err_valid && (w_aw_hs || w_ar_hs)) begin
                r_err_valid <= 1'b1;
                r_err_write <= w_aw_hs;
                r_err_addr  <= w_aw_hs ? aw_addr_i : ar_addr_i;
            end
        end
    end

    assign err_valid_o = r_err_valid;
    assign err_write_o = r_err_write;
    assign err_addr_o  = r_err_addr;
    assign err_count_o = r_err_count;

endmodule

// File: tb/tb_carfield_island_err_resp.sv
// Directed bench for the disabled-island DECERR responder.
// Latency: checks the documented handshake-to-response cycle counts.
// Backpressure: exercises full AR buffer, W-before-AW and r_ready stalls.
module tb_carfield_island_err_resp;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        aw_valid_i, aw_ready_o, w_valid_i, w_ready_o, w_last_i;
    logic        b_valid_o, b_ready_i, ar_valid_i, ar_ready_o;
    logic        r_valid_o, r_ready_i, r_last_o, err_clear_i, err_valid_o, err_write_o;
    logic [5:0]  aw_id_i, b_id_o, ar_id_i, r_id_o;
    logic [47:0] aw_addr_i, ar_addr_i, err_addr_o;
    logic [7:0]  ar_len_i;
    logic [63:0] r_data_o;
    logic [1:0]  b_resp_o, r_resp_o;
    logic [15:0] err_count_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    carfield_island_err_resp dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
        .ar_len_i(ar_len_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
        .r_resp_o(r_resp_o), .r_last_o(r_last_o),
        .err_clear_i(err_clear_i), .err_valid_o(err_valid_o), .err_addr_o(err_addr_o),
        .err_write_o(err_write_o), .err_count_o(err_count_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) tick();
        checks++; if (aw_ready_o !== 1'b0) begin errors++; $display("FAIL reset_aw_ready: got %b want 0", aw_ready_o); end
        checks++; if (ar_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ar_ready: got %b want 0", ar_ready_o); end
        checks++; if (w_ready_o !== 1'b0) begin errors++; $display("FAIL reset_w_ready: got %b want 0", w_ready_o); end
        checks++; if (b_valid_o !== 1'b0) begin errors++; $display("FAIL reset_b_valid: got %b want 0", b_valid_o); end
        checks++; if (r_valid_o !== 1'b0) begin errors++; $display("FAIL reset_r_valid: got %b want 0", r_valid_o); end
        checks++; if (err_valid_o !== 1'b0) begin errors++; $display("FAIL reset_err_valid: got %b want 0", err_valid_o); end
        checks++; if (err_count_o !== 16'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count_o); end
        checks++; if (r_data_o !== 64'd0) begin errors++; $display("FAIL reset_r_data: got %h want 0", r_data_o); end
        rst_i = 1'b0;
        #1;
        checks++; if (aw_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_aw_ready: got %b want 1", aw_ready_o); end
        checks++; if (ar_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ar_ready: got %b want 1", ar_ready_o); end
        tick();
    endtask

    task automatic test_single_write();
        aw_valid_i = 1'b1; aw_id_i = 6'd5; aw_addr_i = 48'h0000_6000_0040;
        checks++; if (aw_ready_o !== 1'b1) begin errors++; $display("FAIL wr_aw_ready: got %b want 1", aw_ready_o); end
        tick();
        aw_valid_i = 1'b0;
        w_valid_i = 1'b1; w_last_i = 1'b1;
        checks++; if (w_ready_o !== 1'b1) begin errors++; $display("FAIL wr_w_ready_next_cycle: got %b want 1", w_ready_o); end
        tick();
        w_valid_i = 1'b0; w_last_i = 1'b0;
        checks++; if (b_valid_o !== 1'b1) begin errors++; $display("FAIL wr_b_valid: got %b want 1", b_valid_o); end
        checks++; if (b_id_o !== 6'd5) begin errors++; $display("FAIL wr_b_id: got %0d want 5", b_id_o); end
        checks++; if (b_resp_o !== 2'b11) begin errors++; $display("FAIL wr_b_resp: got %b want 11", b_resp_o); end
        checks++; if (err_valid_o !== 1'b1) begin errors++; $display("FAIL wr_err_valid: got %b want 1", err_valid_o); end
        checks++; if (err_addr_o !== 48'h0000_6000_0040) begin errors++; $display("FAIL wr_err_addr: got %h want 60000040", err_addr_o); end
        checks++; if (err_write_o !== 1'b1) begin errors++; $display("FAIL wr_err_write: got %b want 1", err_write_o); end
        checks++; if (err_count_o !== 16'd1) begin errors++; $display("FAIL wr_err_count: got %0d want 1", err_count_o); end
        b_ready_i = 1'b1;
        tick();
        b_ready_i = 1'b0;
        repeat (2) tick();
        checks++; if (b_valid_o !== 1'b0) begin errors++; $display("FAIL wr_single_b: got %b want 0", b_valid_o); end
    endtask

    task automatic test_read_burst();
        ar_valid_i = 1'b1; ar_id_i = 6'd9; ar_addr_i = 48'h0000_7000_0000; ar_len_i = 8'd3;
        r_ready_i = 1'b1;
        checks++; if (ar_ready_o !== 1'b1) begin errors++; $display("FAIL rd_ar_ready: got %b want 1", ar_ready_o); end
        tick();
        ar_valid_i = 1'b0;
        checks++; if (r_valid_o !== 1'b0) begin errors++; $display("FAIL rd_early_beat: got %b want 0", r_valid_o); end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (r_valid_o !== 1'b1) begin errors++; $display("FAIL rd_beat%0d_valid: got %b want 1", i, r_valid_o); end
            checks++; if (r_data_o !== 64'hBADC_AB1E_BADC_AB1E) begin errors++; $display("FAIL rd_beat%0d_data: got %h want badcab1ebadcab1e", i, r_data_o); end
            checks++; if (r_id_o !== 6'd9) begin errors++; $display("FAIL rd_beat%0d_id: got %0d want 9", i, r_id_o); end
            checks++; if (r_resp_o !== 2'b11) begin errors++; $display("FAIL rd_beat%0d_resp: got %b want 11", i, r_resp_o); end
            checks++; if (r_last_o !== (i == 3)) begin errors++; $display("FAIL rd_beat%0d_last: got %b want %b", i, r_last_o, (i == 3)); end
            tick();
        end
        checks++; if (r_valid_o !== 1'b0) begin errors++; $display("FAIL rd_after_burst_valid: got %b want 0", r_valid_o); end
        checks++; if (err_count_o !== 16'd2) begin errors++; $display("FAIL rd_err_count: got %0d want 2", err_count_o); end
        checks++; if (err_addr_o !== 48'h0000_6000_0040) begin errors++; $display("FAIL rd_log_kept: got %h want 60000040", err_addr_o); end
        r_ready_i = 1'b0;
    endtask

    task automatic test_ar_backpressure();
        int  got[$];
        bit  ar_done;
        bit  ar_hs_now;
        r_ready_i = 1'b0;
        ar_len_i = 8'd0; ar_addr_i = 48'h0000_7000_1000;
        for (int i = 0; i < 5; i++) begin
            ar_valid_i = 1'b1; ar_id_i = 6'(i + 1);
            if (i < 4) begin
                checks++; if (ar_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ar_ready_%0d: got %b want 1", i, ar_ready_o); end
                tick();
            end else begin
                checks++; if (ar_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ar_full: got %b want 0", ar_ready_o); end
            end
        end
        r_ready_i = 1'b1;
        ar_done = 1'b0;
        for (int c = 0; c < 40 && got.size() < 5; c++) begin
            ar_hs_now = ar_valid_i && ar_ready_o;
            if (r_valid_o) got.push_back(int'(r_id_o));
            tick();
            if (ar_hs_now) begin ar_valid_i = 1'b0; ar_done = 1'b1; end
        end
        ar_valid_i = 1'b0;
        r_ready_i = 1'b0;
        checks++; if (ar_done !== 1'b1) begin errors++; $display("FAIL bp_fifth_accepted: got %b want 1", ar_done); end
        checks++; if (got.size() != 5) begin errors++; $display("FAIL bp_beat_count: got %0d want 5", got.size()); end
        for (int k = 0; k < got.size(); k++) begin
            checks++; if (got[k] != k + 1) begin errors++; $display("FAIL bp_order_%0d: got id %0d want %0d", k, got[k], k + 1); end
        end
        checks++; if (err_count_o !== 16'd7) begin errors++; $display("FAIL bp_err_count: got %0d want 7", err_count_o); end
    endtask

    task automatic test_w_before_aw();
        w_valid_i = 1'b1; w_last_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (w_ready_o !== 1'b0) begin errors++; $display("FAIL wb_held_%0d: got %b want 0", i, w_ready_o); end
            tick();
        end
        aw_valid_i = 1'b1; aw_id_i = 6'd3; aw_addr_i = 48'h0000_0000_1234;
        checks++; if (w_ready_o !== 1'b0) begin errors++; $display("FAIL wb_held_aw_cycle: got %b want 0", w_ready_o); end
        tick();
        aw_valid_i = 1'b0;
        checks++; if (w_ready_o !== 1'b1) begin errors++; $display("FAIL wb_ready_after_aw: got %b want 1", w_ready_o); end
        tick();
        checks++; if (b_valid_o !== 1'b0) begin errors++; $display("FAIL wb_no_early_b: got %b want 0", b_valid_o); end
        w_last_i = 1'b1;
        checks++; if (w_ready_o !== 1'b1) begin errors++; $display("FAIL wb_second_beat_ready: got %b want 1", w_ready_o); end
        tick();
        w_valid_i = 1'b0; w_last_i = 1'b0;
        checks++; if (b_valid_o !== 1'b1) begin errors++; $display("FAIL wb_b_valid: got %b want 1", b_valid_o); end
        checks++; if (b_id_o !== 6'd3) begin errors++; $display("FAIL wb_b_id: got %0d want 3", b_id_o); end
        b_ready_i = 1'b1;
        tick();
        b_ready_i = 1'b0;
        checks++; if (err_count_o !== 16'd8) begin errors++; $display("FAIL wb_err_count: got %0d want 8", err_count_o); end
    endtask

    task automatic test_simultaneous_and_clear();
        int  nb, nr, bid, rid;
        bit  w_hs_now;
        err_clear_i = 1'b1;
        tick();
        err_clear_i = 1'b0;
        checks++; if (err_count_o !== 16'd0) begin errors++; $display("FAIL clr_count: got %0d want 0", err_count_o); end
        checks++; if (err_valid_o !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b want 0", err_valid_o); end
        aw_valid_i = 1'b1; aw_id_i = 6'd2; aw_addr_i = 48'h0000_AAAA_0000;
        ar_valid_i = 1'b1; ar_id_i = 6'd4; ar_addr_i = 48'h0000_BBBB_0000; ar_len_i = 8'd0;
        checks++; if ((aw_ready_o & ar_ready_o) !== 1'b1) begin errors++; $display("FAIL sim_both_ready: got %b%b want 11", aw_ready_o, ar_ready_o); end
        tick();
        aw_valid_i = 1'b0; ar_valid_i = 1'b0;
        checks++; if (err_count_o !== 16'd2) begin errors++; $display("FAIL sim_count: got %0d want 2", err_count_o); end
        checks++; if (err_valid_o !== 1'b1) begin errors++; $display("FAIL sim_valid: got %b want 1", err_valid_o); end
        checks++; if (err_addr_o !== 48'h0000_AAAA_0000) begin errors++; $display("FAIL sim_addr: got %h want aaaa0000", err_addr_o); end
        checks++; if (err_write_o !== 1'b1) begin errors++; $display("FAIL sim_write: got %b want 1", err_write_o); end
        w_valid_i = 1'b1; w_last_i = 1'b1; b_ready_i = 1'b1; r_ready_i = 1'b1;
        nb = 0; nr = 0; bid = -1; rid = -1;
        for (int c = 0; c < 20 && (nb == 0 || nr == 0); c++) begin
            w_hs_now = w_valid_i && w_ready_o;
            if (b_valid_o) begin nb++; bid = int'(b_id_o); end
            if (r_valid_o) begin nr++; rid = int'(r_id_o); end
            tick();
            if (w_hs_now) begin w_valid_i = 1'b0; w_last_i = 1'b0; end
        end
        w_valid_i = 1'b0; w_last_i = 1'b0; b_ready_i = 1'b0;
        checks++; if (nb != 1 || bid != 2) begin errors++; $display("FAIL sim_b: got %0d resp id %0d want 1 resp id 2", nb, bid); end
        checks++; if (nr != 1 || rid != 4) begin errors++; $display("FAIL sim_r: got %0d beats id %0d want 1 beat id 4", nr, rid); end
        ar_valid_i = 1'b1; ar_id_i = 6'd7; ar_addr_i = 48'h0000_CCCC_0000;
        err_clear_i = 1'b1;
        tick();
        ar_valid_i = 1'b0; err_clear_i = 1'b0;
        checks++; if (err_count_o !== 16'd0) begin errors++; $display("FAIL clr_prio_count: got %0d want 0", err_count_o); end
        checks++; if (err_valid_o !== 1'b0) begin errors++; $display("FAIL clr_prio_valid: got %b want 0", err_valid_o); end
        rid = -1;
        for (int c = 0; c < 10; c++) begin
            if (r_valid_o) rid = int'(r_id_o);
            tick();
        end
        checks++; if (rid != 7) begin errors++; $display("FAIL clr_read_served: got id %0d want 7", rid); end
        ar_valid_i = 1'b1; ar_id_i = 6'd1; ar_addr_i = 48'h0000_DDDD_0008;
        tick();
        ar_valid_i = 1'b0;
        checks++; if (err_count_o !== 16'd1) begin errors++; $display("FAIL rd_capture_count: got %0d want 1", err_count_o); end
        checks++; if (err_write_o !== 1'b0) begin errors++; $display("FAIL rd_capture_write: got %b want 0", err_write_o); end
        checks++; if (err_addr_o !== 48'h0000_DDDD_0008) begin errors++; $display("FAIL rd_capture_addr: got %h want dddd0008", err_addr_o); end
        repeat (6) tick();
    endtask

    task automatic test_reset_midburst();
        int nvalid, nbeats, last_at;
        bit bad_id;
        r_ready_i = 1'b1;
        ar_valid_i = 1'b1; ar_id_i = 6'd6; ar_addr_i = 48'h0000_7000_2000; ar_len_i = 8'd3;
        tick();
        ar_valid_i = 1'b0;
        for (int c = 0; c < 10 && !r_valid_o; c++) tick();
        checks++; if (r_valid_o !== 1'b1) begin errors++; $display("FAIL rst_burst_start: got %b want 1", r_valid_o); end
        tick();
        checks++; if (r_last_o !== 1'b0) begin errors++; $display("FAIL rst_beat2_last: got %b want 0", r_last_o); end
        rst_i = 1'b1;
        #1;
        checks++; if (r_valid_o !== 1'b0) begin errors++; $display("FAIL rst_r_valid: got %b want 0", r_valid_o); end
        checks++; if (err_count_o !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", err_count_o); end
        tick();
        rst_i = 1'b0;
        nvalid = 0;
        for (int c = 0; c < 5; c++) begin
            if (r_valid_o) nvalid++;
            tick();
        end
        checks++; if (nvalid != 0) begin errors++; $display("FAIL rst_no_partial: got %0d beats want 0", nvalid); end
        ar_valid_i = 1'b1; ar_id_i = 6'd8; ar_addr_i = 48'h0000_7000_3000; ar_len_i = 8'd1;
        tick();
        ar_valid_i = 1'b0;
        nbeats = 0; last_at = -1; bad_id = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (r_valid_o) begin
                nbeats++;
                if (r_id_o !== 6'd8) bad_id = 1'b1;
                if (r_last_o) last_at = nbeats;
            end
            tick();
        end
        checks++; if (nbeats != 2) begin errors++; $display("FAIL rst_new_read_beats: got %0d want 2", nbeats); end
        checks++; if (last_at != 2) begin errors++; $display("FAIL rst_new_read_last: got beat %0d want 2", last_at); end
        checks++; if (bad_id !== 1'b0) begin errors++; $display("FAIL rst_new_read_id: got bad id flag %b want 0", bad_id); end
        checks++; if (err_count_o !== 16'd1) begin errors++; $display("FAIL rst_new_count: got %0d want 1", err_count_o); end
        r_ready_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        aw_valid_i = 1'b0; aw_id_i = '0; aw_addr_i = '0;
        w_valid_i = 1'b0; w_last_i = 1'b0; b_ready_i = 1'b0;
        ar_valid_i = 1'b0; ar_id_i = '0; ar_addr_i = '0; ar_len_i = '0;
        r_ready_i = 1'b0; err_clear_i = 1'b0;
        test_reset();
        test_single_write();
        test_read_burst();
        test_ar_backpressure();
        test_w_before_aw();
        test_simultaneous_and_clear();
        test_reset_midburst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
